seven_seg_scan: RTL and testbench

SEVEN_SEG_SCAN -- requirements
Module: seven_seg_scan

---
 rtl/seven_seg_scan_pkg.sv | 24 ++
 rtl/seven_seg_scan_ctr.sv | 34 +++
 rtl/seven_seg_scan.sv | 80 ++++++++
 tb/tb_seven_seg_scan.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/seven_seg_scan_pkg.sv
// Shared display constants and types for the multiplexed seven-segment scanner.
// All segment/anode values are active-low.
package seven_seg_scan_pkg;

    localparam logic [7:0] SEG_BLANK = 8'hFF;
    localparam logic [3:0] AN_OFF    = 4'hF;
    localparam int         NUM_DIGITS = 4;

    // 0-9 glyphs, decimal point off (bit 7 high)
    localparam logic [9:0][7:0] SEG_DIGITS = {
        8'h90, 8'h80, 8'hF8, 8'h82, 8'h92,
        8'h99, 8'hB0, 8'hA4, 8'hF9, 8'hC0
    };

    typedef struct packed {
        logic [7:0] pat;
        logic       blank;
    } slot_t;

    function automatic int cnt_w(input int m);
        return (m > 1) ? $clog2(m) : 1;
    endfunction

endpackage

// File: rtl/seven_seg_scan_ctr.sv
// Slot timer: modulo-MOD cycle counter whose wrap advances a 2-bit digit index.
import seven_seg_scan_pkg::*;

module seven_seg_scan_ctr #(
    parameter int MOD = 100000
) (
    input  logic                   clk,
    input  logic                   rst,
    output logic [cnt_w(MOD)-1:0]  cnt,
    output logic [1:0]             sel,
    output logic                   slot_start
);

    localparam int             CW   = cnt_w(MOD);
    localparam logic [CW-1:0]  LAST = CW'(MOD - 1);

    logic wrap;

    assign wrap       = (cnt == LAST);
    assign slot_start = (cnt == '0);

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
            sel <= '0;
        end else if (wrap) begin
            cnt <= '0;
            sel <= sel + 2'd1;
        end else begin
            cnt <= cnt + CW'(1);
        end
    end

endmodule

// File: rtl/seven_seg_scan.sv
// Four-digit time-multiplexed seven-segment driver with per-slot anti-ghost
// blanking and per-digit blinking.
import seven_seg_scan_pkg::*;

module seven_seg_scan #(
    parameter int SCAN_DIV  = 100000,
    parameter int BLANK_CYC = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] digit0_display,
    input  logic [7:0] digit1_display,
    input  logic [7:0] digit2_display,
    input  logic [7:0] digit3_display,
    input  logic       blink_en,
    input  logic [3:0] blink_mask,
    input  logic       blink_tick,
    output logic [7:0] seg,
    output logic [3:0] an,
    output logic [1:0] digit_sel
);

    localparam int            CW        = cnt_w(SCAN_DIV);
    localparam logic [CW-1:0] BLANK_LIM = CW'(BLANK_CYC);

    logic [CW-1:0]                   cnt;
    logic [1:0]                      sel;
    logic                            slot_start;
    logic [NUM_DIGITS-1:0][7:0]      digits;
    logic [NUM_DIGITS-1:0]           an_sel;
    logic                            blink_phase;
    slot_t                           slot;

    assign digits    = {digit3_display, digit2_display, digit1_display, digit0_display};
    assign digit_sel = sel;

    seven_seg_scan_ctr #(.MOD(SCAN_DIV)) u_ctr (
        .clk        (clk),
        .rst        (rst),
        .cnt        (cnt),
        .sel        (sel),
        .slot_start (slot_start)
    );

    // One-hot-low anode decode; exactly one bit low by construction
    for (genvar i = 0; i < NUM_DIGITS; i++) begin : g_an
        assign an_sel[i] = (sel != 2'(i));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            blink_phase <= 1'b0;
            slot        <= '{pat: SEG_BLANK, blank: 1'b0};
            seg         <= SEG_BLANK;
            an          <= AN_OFF;
        end else begin
            if (!blink_en)
                blink_phase <= 1'b0;
            else if (blink_tick)
                blink_phase <= ~blink_phase;

            // Slot contents are frozen at slot start; the old phase is used
            // even if a tick lands on this same edge.
            if (slot_start) begin
                slot.pat   <= digits[sel];
                slot.blank <= blink_en & blink_phase & blink_mask[sel];
            end

            // slot_start implies cnt < BLANK_LIM, so the stale slot is never shown
            if (cnt < BLANK_LIM || slot.blank) begin
                seg <= SEG_BLANK;
                an  <= AN_OFF;
            end else begin
                seg <= slot.pat;
                an  <= an_sel;
            end
        end
    end

endmodule

// File: tb/tb_seven_seg_scan.sv
// Self-checking bench for seven_seg_scan (SCAN_DIV=8, BLANK_CYC=2): directed
// timing tables plus randomized traffic against an edge-count reference model.
module tb_seven_seg_scan;

    localparam int SD = 8;
    localparam int BC = 2;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] dig [4];
    logic       blink_en, blink_tick;
    logic [3:0] blink_mask;
    logic [7:0] seg;
    logic [3:0] an;
    logic [1:0] digit_sel;

    int checks = 0;
    int errors = 0;
    int ecnt   = 0;

    // reference model state
    int         m_n;
    logic [7:0] m_pat;
    logic       m_blank, m_phase;
    logic [7:0] e_seg;
    logic [3:0] e_an;
    logic [1:0] e_sel;

    typedef struct {
        int         lo;
        int         hi;
        logic [3:0] an;
        logic [7:0] seg;
    } vec_t;
    vec_t basic [10];

    seven_seg_scan #(.SCAN_DIV(SD), .BLANK_CYC(BC)) dut (
        .clk            (clk),
        .rst            (rst),
        .digit0_display (dig[0]),
        .digit1_display (dig[1]),
        .digit2_display (dig[2]),
        .digit3_display (dig[3]),
        .blink_en       (blink_en),
        .blink_mask     (blink_mask),
        .blink_tick     (blink_tick),
        .seg            (seg),
        .an             (an),
        .digit_sel      (digit_sel)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at edge %0d: got %0h, expected %0h", nm, ecnt, act, exp);
        end
    endtask

    // Advance one clock edge; the model works from the number of edges since
    // reset: slot position = n mod SD, digit = (n / SD) mod 4.
    task automatic edge_step();
        int pos, s;
        @(posedge clk);
        if (rst) begin
            m_n = 0; m_phase = 1'b0; m_pat = 8'hFF; m_blank = 1'b0;
            e_seg = 8'hFF; e_an = 4'hF; e_sel = 2'd0;
        end else begin
            pos = m_n % SD;
            s   = (m_n / SD) % 4;
            if (pos < BC || m_blank) begin
                e_seg = 8'hFF; e_an = 4'hF;
            end else begin
                e_seg = m_pat; e_an = ~(4'b0001 << s);
            end
            if (pos == 0) begin
                m_pat   = dig[s];
                m_blank = blink_en & m_phase & blink_mask[s];
            end
            if (!blink_en)       m_phase = 1'b0;
            else if (blink_tick) m_phase = ~m_phase;
            m_n++;
            e_sel = 2'((m_n / SD) % 4);
        end
        ecnt++;
        #1;
        chk("seg", 32'(seg), 32'(e_seg));
        chk("an", 32'(an), 32'(e_an));
        chk("digit_sel", 32'(digit_sel), 32'(e_sel));
        chk("an_onehot", 32'($countones(~an) <= 1), 32'd1);
    endtask

    task automatic set_basic_digits();
        dig[0] = 8'hC0; dig[1] = 8'hF9; dig[2] = 8'hA4; dig[3] = 8'hB0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        blink_tick = 1'b0;
        repeat (2) edge_step();
        chk("rst_an", 32'(an), 32'hF);
        chk("rst_seg", 32'(seg), 32'hFF);
        chk("rst_sel", 32'(digit_sel), 32'd0);
        rst  = 1'b0;
        ecnt = 0;
    endtask

    task automatic run_basic_table();
        for (int e = 1; e <= 32; e++) begin
            edge_step();
            for (int r = 0; r < 10; r++) begin
                if (ecnt >= basic[r].lo && ecnt <= basic[r].hi) begin
                    chk("basic_an", 32'(an), 32'(basic[r].an));
                    chk("basic_seg", 32'(seg), 32'(basic[r].seg));
                end
            end
        end
    endtask

    initial begin
        basic[0] = '{1, 2, 4'hF, 8'hFF};
        basic[1] = '{3, 8, 4'hE, 8'hC0};
        basic[2] = '{9, 10, 4'hF, 8'hFF};
        basic[3] = '{11, 16, 4'hD, 8'hF9};
        basic[4] = '{17, 18, 4'hF, 8'hFF};
        basic[5] = '{19, 24, 4'hB, 8'hA4};
        basic[6] = '{25, 26, 4'hF, 8'hFF};
        basic[7] = '{27, 32, 4'h7, 8'hB0};
        basic[8] = '{33, 34, 4'hF, 8'hFF};
        basic[9] = '{35, 40, 4'hE, 8'hC0};

        rst = 1'b1; blink_en = 1'b0; blink_mask = 4'h0; blink_tick = 1'b0;
        set_basic_digits();

        // basic scan timing
        do_reset();
        run_basic_table();

        // mid-slot digit change only shows on that digit's next slot
        set_basic_digits();
        do_reset();
        for (int e = 1; e <= 40; e++) begin
            if (e == 5) dig[0] = 8'h99;
            edge_step();
            if (ecnt >= 3 && ecnt <= 8) chk("midslot_hold", 32'(seg), 32'hC0);
            if (ecnt >= 35) begin
                chk("midslot_an", 32'(an), 32'hE);
                chk("midslot_seg", 32'(seg), 32'h99);
            end
        end

        // blink digit 0: tick at edge 20 darkens it, tick at 60 restores it
        set_basic_digits();
        blink_en = 1'b1; blink_mask = 4'b0001;
        do_reset();
        for (int e = 1; e <= 72; e++) begin
            blink_tick = (e == 20 || e == 60);
            edge_step();
            if (ecnt >= 33 && ecnt <= 64) chk("blink_dark", 32'(an == 4'hE), 32'd0);
            if (ecnt >= 27 && ecnt <= 32) chk("blink_other", 32'(an), 32'h7);
            if (ecnt >= 67) chk("blink_back", 32'(an), 32'hE);
        end
        blink_tick = 1'b0;

        // dropping blink_en mid-slot keeps the slot dark, clears the phase
        do_reset();
        for (int e = 1; e <= 72; e++) begin
            blink_tick = (e == 20);
            if (e == 36) blink_en = 1'b0;
            edge_step();
            if (ecnt >= 33 && ecnt <= 40) chk("bdis_dark", 32'(an), 32'hF);
            if (ecnt >= 67) begin
                chk("bdis_an", 32'(an), 32'hE);
                chk("bdis_seg", 32'(seg), 32'hC0);
            end
        end
        blink_tick = 1'b0; blink_mask = 4'h0;

        // reset mid-slot while digit 2 is lit, then the scan restarts cleanly
        do_reset();
        for (int e = 1; e <= 20; e++) edge_step();
        rst = 1'b1;
        edge_step();
        chk("midrst_an", 32'(an), 32'hF);
        chk("midrst_seg", 32'(seg), 32'hFF);
        chk("midrst_sel", 32'(digit_sel), 32'd0);
        rst  = 1'b0;
        ecnt = 0;
        run_basic_table();

        // randomized traffic against the model
        for (int e = 0; e < 4000; e++) begin
            if ($urandom_range(0, 15) == 0) dig[$urandom_range(0, 3)] = 8'($urandom);
            if ($urandom_range(0, 99) == 0) blink_en = ~blink_en;
            if ($urandom_range(0, 63) == 0) blink_mask = 4'($urandom);
            blink_tick = ($urandom_range(0, 19) == 0);
            rst = ($urandom_range(0, 599) == 0);
            edge_step();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
